// File: rtl/binupdn_cnt_param_pkg.sv
// Shared constants, op encoding and decode helper
// for the parametrised up/down counter.
package binupdn_cnt_param_pkg;

  localparam int CNT_BIT_WIDTH = 4;
  localparam int CNT_WRAP      = 0;
  localparam int CNT_SAT       = 1;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_UP,
    OP_DN
  } cnt_op_e;

  // clr beats load beats en; terms kept disjoint
  function automatic cnt_op_e cnt_decode(
    input logic clr,
    input logic load,
    input logic en,
    input logic up
  );
    cnt_op_e op;
    op = OP_HOLD;
    unique case (1'b1)
      clr:                          op = OP_CLR;
      !clr && load:                 op = OP_LOAD;
      !clr && !load && en && up:    op = OP_UP;
      !clr && !load && en && !up:   op = OP_DN;
      default:                      op = OP_HOLD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/binupdn_cnt_param_if.sv
// Control/status bundle of the counter.
// master drives controls, slave is the counter.
interface binupdn_cnt_param_if
  import binupdn_cnt_param_pkg::*;
#(
  parameter int WIDTH = CNT_BIT_WIDTH
) ();

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             roll;

  modport master (
    output en, up, clr, load, d,
    input  q, tc, roll
  );

  modport slave (
    input  en, up, clr, load, d,
    output q, tc, roll
  );

endinterface

// File: rtl/binupdn_cnt_next.sv
// Next-count and terminal-count logic.
// Pure combinational; en arrives reset-qualified.
module binupdn_cnt_next
  import binupdn_cnt_param_pkg::*;
#(
  parameter int WIDTH    = CNT_BIT_WIDTH,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             up,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_nxt,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam bit SAT = (SATURATE == CNT_SAT);

  cnt_op_e op;
  logic    at_max;
  logic    at_zero;

  assign op      = cnt_decode(clr, load, en, up);
  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

  // boundary flag for cascading, valid same cycle
  assign tc = en & ((up & at_max) | (~up & at_zero));

  // explicit compare against MAX, never rely on overflow
  always_comb begin
    q_nxt = q;
    unique case (op)
      OP_CLR:  q_nxt = '0;
      OP_LOAD: q_nxt = (d > MAX) ? MAX : d;
      OP_UP:   q_nxt = at_max ? (SAT ? MAX : '0)
                              : q + ONE;
      OP_DN:   q_nxt = at_zero ? (SAT ? '0 : MAX)
                               : q - ONE;
      default: q_nxt = q;
    endcase
  end

endmodule

// File: rtl/binupdn_cnt_param.sv
// Modulo-N up/down counter, wrap or saturate.
// Holds only the count and rollover registers.
module binupdn_cnt_param
  import binupdn_cnt_param_pkg::*;
#(
  parameter int WIDTH    = CNT_BIT_WIDTH,
  parameter int MODULUS  = 16,
  parameter int SATURATE = CNT_WRAP
) (
  input logic               clk,
  input logic               rst_n,
  binupdn_cnt_param_if.slave bus
);

  generate
    if (MODULUS > (2 ** WIDTH) || MODULUS < 2) begin : g_bad_mod
      $error("binupdn_cnt_param: MODULUS out of range");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_sat
      $error("binupdn_cnt_param: SATURATE must be 0 or 1");
    end
  endgenerate

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             roll;
  logic             tc;
  logic             en_q;

  // tc must read low while reset is held
  assign en_q = bus.en & rst_n;

  binupdn_cnt_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS),
    .SATURATE(SATURATE)
  ) u_next (
    .q    (q),
    .up   (bus.up),
    .en   (en_q),
    .clr  (bus.clr),
    .load (bus.load),
    .d    (bus.d),
    .q_nxt(q_nxt),
    .tc   (tc)
  );

  // count register plus boundary pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      roll <= 1'b0;
    end else begin
      q    <= q_nxt;
      roll <= tc & ~bus.clr & ~bus.load;
    end
  end

  assign bus.q    = q;
  assign bus.tc   = tc;
  assign bus.roll = roll;

endmodule

// File: tb/tb_binupdn_cnt_param.sv
// Directed vector bench for binupdn_cnt_param:
// wrap, saturate, load/clr, reset, cascade.
module tb_binupdn_cnt_param;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  binupdn_cnt_param_if #(.WIDTH(4)) if0 ();
  binupdn_cnt_param_if #(.WIDTH(4)) if1 ();
  binupdn_cnt_param_if #(.WIDTH(4)) if2 ();
  binupdn_cnt_param_if #(.WIDTH(4)) ifl ();
  binupdn_cnt_param_if #(.WIDTH(4)) ifh ();

  binupdn_cnt_param u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave)
  );
  binupdn_cnt_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave)
  );
  binupdn_cnt_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave)
  );
  binupdn_cnt_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(0)
  ) ul (
    .clk(clk), .rst_n(rst_n), .bus(ifl.slave)
  );
  binupdn_cnt_param #(
    .WIDTH(4), .MODULUS(10), .SATURATE(0)
  ) uh (
    .clk(clk), .rst_n(rst_n), .bus(ifh.slave)
  );

  assign ifh.en = ifl.tc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;
    bit         en;
    bit         up;
    bit         clr;
    bit         load;
    logic [3:0] d;
    logic [3:0] q;
    bit         tc;
    bit         roll;
    string      nm;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    int sel, bit en, bit up, bit clr, bit load,
    int d, int q, bit tc, bit roll, string nm
  );
    vec_t v;
    v.sel = sel; v.en = en; v.up = up;
    v.clr = clr; v.load = load;
    v.d = 4'(d); v.q = 4'(q);
    v.tc = tc; v.roll = roll; v.nm = nm;
    return v;
  endfunction

  task automatic chk(string nm, logic [7:0] act,
                     logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  task automatic drive(int sel, bit en, bit up,
                       bit clr, bit load,
                       logic [3:0] d);
    case (sel)
      0: begin
        if0.en = en; if0.up = up; if0.clr = clr;
        if0.load = load; if0.d = d;
      end
      1: begin
        if1.en = en; if1.up = up; if1.clr = clr;
        if1.load = load; if1.d = d;
      end
      default: begin
        if2.en = en; if2.up = up; if2.clr = clr;
        if2.load = load; if2.d = d;
      end
    endcase
  endtask

  task automatic sample(int sel, output logic [3:0] q,
                        output logic tc,
                        output logic roll);
    case (sel)
      0: begin q = if0.q; tc = if0.tc; roll = if0.roll; end
      1: begin q = if1.q; tc = if1.tc; roll = if1.roll; end
      default: begin
        q = if2.q; tc = if2.tc; roll = if2.roll;
      end
    endcase
  endtask

  initial begin
    logic [3:0] q;
    logic       tc;
    logic       roll;
    int         hc;

    rst_n = 1'b0;
    for (int s = 0; s < 3; s++) drive(s, 0, 0, 0, 0, 0);
    ifl.up = 1'b1; ifl.en = 1'b0; ifl.clr = 1'b0;
    ifl.load = 1'b0; ifl.d = '0;
    ifh.up = 1'b1; ifh.clr = 1'b0;
    ifh.load = 1'b0; ifh.d = '0;
    // down-counter at 0 would flag tc if not reset-gated
    drive(1, 1, 0, 0, 0, 0);

    // vector table
    for (int k = 1; k <= 17; k++)
      vq.push_back(mk(0, 1, 1, 0, 0, 0, k % 16,
                      (k % 16) == 15, k == 16, "t1_up"));
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, "t1_hold"));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 9, 0, 1, "t2_first"));
    for (int k = 2; k <= 10; k++)
      vq.push_back(mk(1, 1, 0, 0, 0, 0, 10 - k,
                      k == 10, 0, "t2_dn"));
    vq.push_back(mk(1, 1, 0, 0, 0, 0, 9, 0, 1, "t2_wrap"));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 1, "t2_dirchg"));
    vq.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 0, "t2_up"));
    vq.push_back(mk(1, 0, 1, 0, 1, 12, 9, 0, 0, "t4_clamp_w"));
    vq.push_back(mk(2, 0, 1, 0, 1, 7, 7, 0, 0, "t3_load"));
    vq.push_back(mk(2, 1, 1, 0, 0, 0, 8, 0, 0, "t3_8"));
    vq.push_back(mk(2, 1, 1, 0, 0, 0, 9, 1, 0, "t3_9"));
    vq.push_back(mk(2, 1, 1, 0, 0, 0, 9, 1, 1, "t3_sat1"));
    vq.push_back(mk(2, 1, 1, 0, 0, 0, 9, 1, 1, "t3_sat2"));
    vq.push_back(mk(2, 0, 1, 0, 0, 0, 9, 0, 0, "t3_off"));
    vq.push_back(mk(2, 0, 1, 1, 0, 0, 0, 0, 0, "t3_clr"));
    vq.push_back(mk(2, 1, 0, 0, 0, 0, 0, 1, 1, "t3_satdn"));
    vq.push_back(mk(2, 1, 0, 0, 0, 0, 0, 1, 1, "t3_satdn2"));
    vq.push_back(mk(2, 1, 0, 0, 1, 12, 9, 0, 0, "t4_clamp"));
    vq.push_back(mk(2, 1, 1, 1, 1, 5, 0, 0, 0, "t4_clrld"));
    vq.push_back(mk(2, 0, 1, 0, 1, 9, 9, 0, 0, "t4_ldmax"));
    vq.push_back(mk(2, 0, 0, 0, 1, 3, 3, 0, 0, "t4_ld3"));
    vq.push_back(mk(2, 1, 0, 0, 0, 0, 2, 0, 0, "t4_dn"));
    vq.push_back(mk(2, 0, 0, 0, 0, 0, 2, 0, 0, "t3_hold"));

    // reset state
    #1;
    for (int s = 0; s < 3; s++) begin
      sample(s, q, tc, roll);
      chk("rst_q", q, 0);
      chk("rst_roll", roll, 0);
    end
    chk("rst_tc", if1.tc, 0);
    #6;
    chk("rst_hold_q", if1.q, 0);
    #3;
    rst_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);

    foreach (vq[i]) begin
      drive(vq[i].sel, vq[i].en, vq[i].up,
            vq[i].clr, vq[i].load, vq[i].d);
      @(posedge clk);
      #1;
      sample(vq[i].sel, q, tc, roll);
      chk({vq[i].nm, "_q"}, q, vq[i].q);
      chk({vq[i].nm, "_tc"}, tc, vq[i].tc);
      chk({vq[i].nm, "_roll"}, roll, vq[i].roll);
    end

    // async reset between edges at q=6
    drive(0, 0, 1, 0, 1, 5);
    @(posedge clk); #1;
    chk("t5_ld", if0.q, 5);
    drive(0, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("t5_six", if0.q, 6);
    drive(0, 1, 0, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_async_q", if0.q, 0);
    chk("t5_async_roll", if0.roll, 0);
    chk("t5_async_tc", if0.tc, 0);
    @(posedge clk); #1;
    chk("t5_held_q", if0.q, 0);
    rst_n = 1'b1;
    drive(0, 1, 1, 0, 0, 0);
    @(posedge clk); #1;
    chk("t5_resume_q", if0.q, 1);
    chk("t5_resume_roll", if0.roll, 0);
    drive(0, 0, 1, 0, 0, 0);

    // two-digit decade cascade
    hc = 0;
    ifl.en = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk); #1;
      chk("t6_cnt", {ifh.q, ifl.q},
          8'(((k / 10) % 10) * 16 + (k % 10)));
      chk("t6_hitc", ifh.tc, k == 99);
      if (ifh.tc) hc++;
    end
    ifl.en = 1'b0;
    chk("t6_hitc_n", 8'(hc), 1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
